// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundle between the round-robin arbiter, its requesters and the shared
// uart_tx byte transmitter.
//   i_Req        per-requester byte-pending flags
//   i_Req_Byte   byte of requester k at [8k+7:8k]
//   o_Grant      one-hot, one-cycle capture pulse
//   o_Owner      index of the current/last granted requester
//   o_Busy       arbiter owns the transmitter (launch .. back in IDLE)
//   o_Tx_DV      one-cycle launch strobe to the transmitter
//   o_Tx_Byte    byte to the transmitter, held until the next launch
//   i_Tx_Active  transmitter active flag
//   i_Tx_Done    transmitter done flag (2 cycles high per frame)
// Modports: master = arbiter side, slave = requesters + transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   i_Req;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   o_Grant;
  logic [OW-1:0]        o_Owner;
  logic                 o_Busy;
  logic                 o_Tx_DV;
  logic [7:0]           o_Tx_Byte;
  logic                 i_Tx_Active;
  logic                 i_Tx_Done;

  modport master (
    input  i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
    output o_Grant, o_Owner, o_Busy, o_Tx_DV, o_Tx_Byte
  );

  modport slave (
    output i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Grant, o_Owner, o_Busy, o_Tx_DV, o_Tx_Byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin scheduler sharing one uart_tx byte transmitter among NUM_REQ
// requesters. One requester is granted per frame; the next launch only
// happens once the transmitter has signalled done and dropped it again.
// Ports:
//   i_Clock  rising-edge clock
//   i_Rst_L  asynchronous active-low reset
//   bus      uart_tx_arbiter_if.master (requests, grant, transmitter strobe)
// Parameters: NUM_REQ (2..8), GAP_CLKS (idle clocks after each frame).
// Build option: define UART_ARB_GAP_EN to compile in the GAP state and its
// counter; without it RELEASE returns straight to IDLE and GAP_CLKS is unused.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// SYNC      | after reset: wait for transmitter idle (active=0, done=0)
// IDLE      | arbitrate; launch the winning requester's byte
// WAIT_DONE | frame in flight, wait for done to rise
// RELEASE   | wait for done to fall
// GAP       | (UART_ARB_GAP_EN only) GAP_CLKS idle clocks before IDLE
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int GAP_CLKS = 16
) (
  input logic               i_Clock,
  input logic               i_Rst_L,
  uart_tx_arbiter_if.master bus
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CLKS < 1) begin : g_bad_cfg
      $error("uart_tx_arbiter: unsupported NUM_REQ or GAP_CLKS");
    end
  endgenerate

`ifdef UART_ARB_GAP_EN
  typedef enum logic [2:0] {
    SYNC = 3'd0, IDLE = 3'd1, WAIT_DONE = 3'd2, RELEASE = 3'd3, GAP = 3'd4
  } state_t;
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`else
  typedef enum logic [2:0] {
    SYNC = 3'd0, IDLE = 3'd1, WAIT_DONE = 3'd2, RELEASE = 3'd3
  } state_t;
`endif

  state_t               state_q, state_d;
  logic                 dv_q, dv_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           byte_q, byte_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic                 busy_q, busy_d;

  logic                 sel_found;
  logic [OW-1:0]        sel_idx;
  logic [7:0]           sel_byte;
  logic [NUM_REQ-1:0]   sel_onehot;

  // Search starts one past the last owner and wraps, so the last served
  // requester always has the lowest priority.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = owner_q;
    sel_byte   = 8'h00;
    sel_onehot = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!sel_found && bus.i_Req[k] && (((int'(owner_q) + i) % NUM_REQ) == k)) begin
          sel_found     = 1'b1;
          sel_idx       = OW'(k);
          sel_byte      = bus.i_Req_Byte[8*k +: 8];
          sel_onehot[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dv_d    = 1'b0;
    grant_d = '0;
    byte_d  = byte_q;
    owner_d = owner_q;
    busy_d  = busy_q;
`ifdef UART_ARB_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      SYNC: begin
        if (!bus.i_Tx_Active && !bus.i_Tx_Done) state_d = IDLE;
      end
      IDLE: begin
        if (sel_found) begin
          dv_d    = 1'b1;
          grant_d = sel_onehot;
          byte_d  = sel_byte;
          owner_d = sel_idx;
          busy_d  = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.i_Tx_Done) state_d = RELEASE;
      end
      RELEASE: begin
        if (!bus.i_Tx_Done) begin
`ifdef UART_ARB_GAP_EN
          state_d   = GAP;
          gap_cnt_d = GW'(GAP_CLKS - 1);
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end
      end
`ifdef UART_ARB_GAP_EN
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
`endif
      default: begin
        state_d = SYNC;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= SYNC;
      dv_q    <= 1'b0;
      grant_q <= '0;
      byte_q  <= 8'h00;
      owner_q <= OW'(NUM_REQ - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q    <= dv_d;
      grant_q <= grant_d;
      byte_q  <= byte_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_ARB_GAP_EN
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) gap_cnt_q <= '0;
    else          gap_cnt_q <= gap_cnt_d;
  end
`endif

  assign bus.o_Tx_DV   = dv_q;
  assign bus.o_Grant   = grant_q;
  assign bus.o_Tx_Byte = byte_q;
  assign bus.o_Owner   = owner_q;
  assign bus.o_Busy    = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with NUM_REQ=4 and a behavioural companion
// transmitter (CLKS_PER_BIT=4, done held for 2 cycles).
module tb_uart_tx_arbiter;
  localparam int NR  = 4;
  localparam int C   = 4;
  localparam int GAP = 16;
`ifdef UART_ARB_GAP_EN
  localparam int SPACING = 10*C + 5 + GAP;
`else
  localparam int SPACING = 10*C + 5;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]   req      = '0;
  logic [8*NR-1:0] req_byte = '0;
  logic            tx_active = 1'b0;
  logic            tx_done   = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();
  assign bus.i_Req       = req;
  assign bus.i_Req_Byte  = req_byte;
  assign bus.i_Tx_Active = tx_active;
  assign bus.i_Tx_Done   = tx_done;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CLKS(GAP)) dut (
    .i_Clock(clk),
    .i_Rst_L(rst_n),
    .bus    (bus)
  );

  // companion transmitter: no reset, like the real one
  typedef enum {T_IDLE, T_START, T_DATA, T_STOP, T_CLEAN} tstate_t;
  tstate_t    ts    = T_IDLE;
  int         tcnt  = 0;
  int         tbit  = 0;
  logic [7:0] tdata = 8'h00;
  logic       serial;
  assign serial = (ts == T_START) ? 1'b0 : (ts == T_DATA) ? tdata[tbit] : 1'b1;

  always @(posedge clk) begin
    case (ts)
      T_IDLE: begin
        tx_done <= 1'b0;
        if (bus.o_Tx_DV) begin
          tx_active <= 1'b1;
          tdata     <= bus.o_Tx_Byte;
          tcnt      <= 0;
          ts        <= T_START;
        end
      end
      T_START: begin
        if (tcnt < C-1) tcnt <= tcnt + 1;
        else begin tcnt <= 0; tbit <= 0; ts <= T_DATA; end
      end
      T_DATA: begin
        if (tcnt < C-1) tcnt <= tcnt + 1;
        else begin
          tcnt <= 0;
          if (tbit < 7) tbit <= tbit + 1;
          else ts <= T_STOP;
        end
      end
      T_STOP: begin
        if (tcnt < C-1) tcnt <= tcnt + 1;
        else begin tcnt <= 0; tx_done <= 1'b1; tx_active <= 1'b0; ts <= T_CLEAN; end
      end
      default: begin tx_done <= 1'b1; ts <= T_IDLE; end
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // running protocol monitors
  int   dv_double = 0, dv_bad = 0, grant1_cnt = 0;
  logic prev_dv = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_Tx_DV && prev_dv) dv_double = dv_double + 1;
      if (bus.o_Tx_DV && (tx_active || tx_done)) dv_bad = dv_bad + 1;
      if (bus.o_Grant[1]) grant1_cnt = grant1_cnt + 1;
      prev_dv = bus.o_Tx_DV;
    end else begin
      prev_dv = 1'b0;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_dv(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.o_Tx_DV) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.o_Busy) begin ok = 1'b1; break; end
    end
    chk("busy_fall", ok, 1);
    chk("busy_after_done_clear", tx_done, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] bytes;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_byte;
    logic [1:0]  exp_owner;
  } vec_t;
  vec_t vecs[8];

  initial begin
    bit          ok;
    logic [9:0]  frame;
    int          last_cyc;
    int          g1_before;
    int          early_dv;
    logic [3:0]  order_g[5];
    logic [3:0]  fair_g[4];

    vecs[0] = '{4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5, 2'd2};
    vecs[1] = '{4'b1011, 32'h3C00_2B1A, 4'b1000, 8'h3C, 2'd3};
    vecs[2] = '{4'b0011, 32'h0000_5E4D, 4'b0001, 8'h4D, 2'd0};
    vecs[3] = '{4'b0011, 32'h0000_7F6E, 4'b0010, 8'h7F, 2'd1};
    vecs[4] = '{4'b0001, 32'h0000_0081, 4'b0001, 8'h81, 2'd0};
    vecs[5] = '{4'b1100, 32'hC3B2_0000, 4'b0100, 8'hB2, 2'd2};
    vecs[6] = '{4'b1111, 32'hF4E3_D2C1, 4'b1000, 8'hF4, 2'd3};
    vecs[7] = '{4'b0110, 32'h0096_8700, 4'b0010, 8'h87, 2'd1};
    order_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fair_g  = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_dv",    bus.o_Tx_DV, 0);
    chk("rst_grant", bus.o_Grant, 0);
    chk("rst_busy",  bus.o_Busy, 0);
    chk("rst_byte",  bus.o_Tx_Byte, 8'h00);
    chk("rst_owner", bus.o_Owner, 3);
    rst_n = 1'b1;

    // table: one frame per row, owner carried from the previous row
    for (int r = 0; r < 8; r++) begin
      req      = vecs[r].req;
      req_byte = vecs[r].bytes;
      wait_dv(200, ok);
      chk("row_dv_seen", ok, 1);
      chk("row_grant", bus.o_Grant, vecs[r].exp_grant);
      chk("row_byte",  bus.o_Tx_Byte, vecs[r].exp_byte);
      chk("row_owner", bus.o_Owner, vecs[r].exp_owner);
      chk("row_busy",  bus.o_Busy, 1);
      req = '0;
      @(negedge clk);
      chk("row_dv_pulse", {bus.o_Tx_DV, bus.o_Grant}, 0);
      repeat (C/2) @(negedge clk);
      frame[0] = serial;
      for (int b = 1; b < 10; b++) begin
        repeat (C) @(negedge clk);
        frame[b] = serial;
      end
      chk("row_serial", frame, {1'b1, vecs[r].exp_byte, 1'b0});
      wait_idle();
    end

    // all four held: order 0,1,2,3,0 with fixed DV spacing
    do_reset();
    req      = 4'b1111;
    req_byte = 32'h1312_1110;
    last_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      wait_dv(200, ok);
      chk("rr_dv_seen", ok, 1);
      chk("rr_grant", bus.o_Grant, order_g[n]);
      chk("rr_byte", bus.o_Tx_Byte, 8'h10 + ((n == 4) ? 8'd0 : 8'(n)));
      if (n > 0) chk("rr_spacing", cyc - last_cyc, SPACING);
      last_cyc = cyc;
    end
    req = '0;
    wait_idle();

    // fairness: req0 re-raised after each grant, req2 stays pending
    do_reset();
    req      = 4'b0101;
    req_byte = 32'h00B2_00A0;
    for (int n = 0; n < 4; n++) begin
      wait_dv(200, ok);
      chk("fair_dv_seen", ok, 1);
      chk("fair_grant", bus.o_Grant, fair_g[n]);
      if (bus.o_Grant[0]) begin
        req[0] = 1'b0;
        @(negedge clk);
        req[0] = 1'b1;
      end
    end
    req = '0;
    wait_idle();

    // withdraw: req1 raised in WAIT_DONE and dropped before its turn
    do_reset();
    req      = 4'b0001;
    req_byte = 32'hD300_B1A0;
    wait_dv(200, ok);
    chk("wd_first_grant", bus.o_Grant, 4'b0001);
    req = '0;
    g1_before = grant1_cnt;
    repeat (3) @(negedge clk);
    req = 4'b1010;
    repeat (5) @(negedge clk);
    req = 4'b1000;
    wait_dv(200, ok);
    chk("wd_dv_seen", ok, 1);
    chk("wd_grant", bus.o_Grant, 4'b1000);
    chk("wd_byte", bus.o_Tx_Byte, 8'hD3);
    chk("wd_no_grant1", grant1_cnt - g1_before, 0);
    req = '0;
    wait_idle();

    // reset mid-frame while the transmitter keeps running
    do_reset();
    req      = 4'b0100;
    req_byte = 32'h0066_0055;
    wait_dv(200, ok);
    chk("mr_grant", bus.o_Grant, 4'b0100);
    req = '0;
    repeat (3*C) @(negedge clk);
    req   = 4'b0101;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_dv",    bus.o_Tx_DV, 0);
    chk("mr_rst_grant", bus.o_Grant, 0);
    chk("mr_rst_busy",  bus.o_Busy, 0);
    chk("mr_rst_byte",  bus.o_Tx_Byte, 8'h00);
    chk("mr_rst_owner", bus.o_Owner, 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    early_dv = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!tx_active && !tx_done) break;
      if (bus.o_Tx_DV) early_dv++;
    end
    chk("mr_no_early_dv", early_dv, 0);
    wait_dv(200, ok);
    chk("mr_dv_seen", ok, 1);
    chk("mr_grant_after", bus.o_Grant, 4'b0001);
    chk("mr_byte_after", bus.o_Tx_Byte, 8'h55);
    req = '0;
    wait_idle();

    chk("dv_never_double", dv_double, 0);
    chk("dv_only_when_tx_idle", dv_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
